alu_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single 32-bit ALU between two requesters, for example the EX stage and the address/branch helper unit. It accepts one operation at a time over a valid/ready handshake and runs it for a per-opcode latency, with MUL optionally multi-cycle. It returns the result, the equality-zero flag and the requester ID on a back-pressured response channel. The block sits between the requesters and the ALU datapath and owns all ALU sequencing.

---
 rtl/alu_share_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter and sequencer sharing one 32-bit ALU between two requesters.
// Optional macro ALU_ARB_MUL_MULTICYCLE_EN makes MUL occupy EXEC for MUL_CYCLES cycles.
module alu_share_arbiter #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [2:0]  req0_op_i,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [2:0]  req1_op_i,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic        resp_id_o,
    output logic [31:0] resp_data_o,
    output logic        resp_zero_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_MUL = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;

`ifdef ALU_ARB_MUL_MULTICYCLE_EN
    localparam bit MUL_MC = 1'b1;
`else
    localparam bit MUL_MC = 1'b0;
`endif
    // Counter holds remaining EXEC cycles minus one, so MUL loads MUL_CYCLES-1.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_t      state_q, state_d;
    logic        prio_q;
    logic [3:0]  cnt_q;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic        id_q;
    logic [31:0] data_q;
    logic        zero_q;

    logic        grant0, grant1, accept;
    logic [2:0]  sel_op;
    logic [31:0] sel_a, sel_b;
    logic [3:0]  load_cnt;
    logic [31:0] alu_result;

    assign grant0       = req0_valid_i && (!req1_valid_i || !prio_q);
    assign grant1       = req1_valid_i && (!req0_valid_i ||  prio_q);
    assign req0_ready_o = (state_q == IDLE) && grant0 && !rst_i;
    assign req1_ready_o = (state_q == IDLE) && grant1 && !rst_i;
    assign accept       = req0_ready_o || req1_ready_o;

    assign sel_op   = grant1 ? req1_op_i : req0_op_i;
    assign sel_a    = grant1 ? req1_a_i  : req0_a_i;
    assign sel_b    = grant1 ? req1_b_i  : req0_b_i;
    assign load_cnt = (MUL_MC && sel_op == OP_MUL) ? MUL_LOAD : 4'd0;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        alu_result = 32'd0;
        case (op_q)
            OP_ADD:  alu_result = a_q + b_q;
            OP_MUL:  alu_result = a_q * b_q;
            OP_SUB:  alu_result = a_q - b_q;
            OP_AND:  alu_result = a_q & b_q;
            OP_OR:   alu_result = a_q | b_q;
            default: alu_result = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    if (cnt_q == 4'd0) state_d = DONE;
            DONE:    if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            id_q    <= 1'b0;
            data_q  <= 32'd0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= sel_op;
                a_q    <= sel_a;
                b_q    <= sel_b;
                id_q   <= grant1;
                cnt_q  <= load_cnt;
                prio_q <= !grant1;
            end else if (state_q == EXEC) begin
                if (cnt_q == 4'd0) begin
                    data_q <= alu_result;
                    zero_q <= (a_q - b_q) == 32'd0;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
            end
        end
    end

    assign resp_valid_o = (state_q == DONE);
    assign resp_id_o    = id_q;
    assign resp_data_o  = data_q;
    assign resp_zero_o  = zero_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: cycle-level reference model plus directed scenarios.
// Honours ALU_ARB_MUL_MULTICYCLE_EN for the expected MUL latency.
module tb_alu_share_arbiter;

    localparam int MUL_CYCLES = 4;
`ifdef ALU_ARB_MUL_MULTICYCLE_EN
    localparam int MUL_LAT = MUL_CYCLES;
`else
    localparam int MUL_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op = 3'd0, req1_op = 3'd0;
    logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
    logic        resp_valid, resp_id, resp_zero, busy;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    alu_share_arbiter #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_op_i    (req0_op),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_op_i    (req1_op),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_id_o    (resp_id),
        .resp_data_o  (resp_data),
        .resp_zero_o  (resp_zero),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] prod;
        prod = 64'(a) * 64'(b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return prod[31:0];
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op);
        return (op == 3'd1) ? MUL_LAT : 1;
    endfunction

    // Reference model: one job in flight, counted down in whole cycles until its response is due.
    bit          m_busy, m_done, m_prio, m_id, m_zero;
    int          m_wait;
    logic [31:0] m_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_prio <= 1'b0;
            m_wait <= 0;
        end else if (!m_busy) begin
            if (req0_valid && (!req1_valid || !m_prio)) begin
                m_busy <= 1'b1;
                m_id   <= 1'b0;
                m_prio <= 1'b1;
                m_wait <= ref_latency(req0_op);
                m_data <= ref_result(req0_op, req0_a, req0_b);
                m_zero <= (req0_a == req0_b);
            end else if (req1_valid) begin
                m_busy <= 1'b1;
                m_id   <= 1'b1;
                m_prio <= 1'b0;
                m_wait <= ref_latency(req1_op);
                m_data <= ref_result(req1_op, req1_a, req1_b);
                m_zero <= (req1_a == req1_b);
            end
        end else if (!m_done) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) m_done <= 1'b1;
        end else if (resp_ready) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("ready0", 32'(req0_ready),
              32'(!rst && !m_busy && req0_valid && (!req1_valid || !m_prio)));
        check("ready1", 32'(req1_ready),
              32'(!rst && !m_busy && req1_valid && (!req0_valid || m_prio)));
        check("busy", 32'(busy), 32'(m_busy));
        check("resp_valid", 32'(resp_valid), 32'(m_done));
        if (m_done) begin
            check("resp_id", 32'(resp_id), 32'(m_id));
            check("resp_data", resp_data, m_data);
            check("resp_zero", 32'(resp_zero), 32'(m_zero));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input int who, output int n);
        bit found = 1'b0;
        n = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if ((who == 0 && req0_ready) || (who == 1 && req1_ready)) begin
                found = 1'b1;
                n = cyc;
            end
        end
        if (!found) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_any_grant(output int who);
        bit found = 1'b0;
        who = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                found = 1'b1;
                who = req1_ready ? 1 : 0;
            end
        end
        if (!found) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid(output int n);
        bit found = 1'b0;
        n = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                found = 1'b1;
                n = cyc;
            end
        end
        if (!found) check("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        int n, m, h, who;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_id", 32'(resp_id), 32'd0);
        check("rst_data", resp_data, 32'd0);
        check("rst_zero", 32'(resp_zero), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;

        // Single requester ADD 5+7
        req0_op = 3'd0; req0_a = 32'd5; req0_b = 32'd7; req0_valid = 1'b1;
        wait_accept(0, n);
        step();
        req0_valid = 1'b0;
        wait_valid(m);
        check("add_latency", 32'(m - n), 32'd2);
        check("add_data", resp_data, 32'd12);
        check("add_id", 32'(resp_id), 32'd0);
        check("add_zero", 32'(resp_zero), 32'd0);
        step();

        // Contention round-robin from a fresh pointer
        do_reset();
        req0_op = 3'd2; req0_a = 32'd9;    req0_b = 32'd9;
        req1_op = 3'd4; req1_a = 32'hF0;   req1_b = 32'h0F;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_any_grant(who);
            check("rr_order", 32'(who), 32'(i % 2));
            wait_valid(m);
            check("rr_data", resp_data, (i % 2 == 0) ? 32'd0 : 32'hFF);
            check("rr_zero", 32'(resp_zero), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;

        // MUL latency on requester 1
        req1_op = 3'd1; req1_a = 32'h10000; req1_b = 32'h10000; req1_valid = 1'b1;
        wait_accept(1, n);
        step();
        req1_valid = 1'b0;
        wait_valid(m);
        check("mul_latency", 32'(m - n), 32'(MUL_LAT + 1));
        check("mul_data", resp_data, 32'd0);
        check("mul_id", 32'(resp_id), 32'd1);
        step();

        // Back-pressure with the other requester waiting
        resp_ready = 1'b0;
        req0_op = 3'd3; req0_a = 32'hFF00FF00; req0_b = 32'h0F0F0F0F; req0_valid = 1'b1;
        req1_op = 3'd0; req1_a = 32'd1;        req1_b = 32'd2;        req1_valid = 1'b1;
        wait_accept(0, n);
        step();
        req0_valid = 1'b0;
        wait_valid(m);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_data", resp_data, 32'h0F000F00);
            check("bp_id", 32'(resp_id), 32'd0);
            check("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
        end
        step();
        resp_ready = 1'b1;
        h = cyc;
        wait_accept(1, n);
        check("bp_next_grant", 32'(n), 32'(h + 1));
        step();
        req1_valid = 1'b0;
        wait_valid(m);
        check("bp_second_data", resp_data, 32'd3);
        step();

        // Reset during EXEC of a MUL
        req0_op = 3'd1; req0_a = 32'd3; req0_b = 32'd5; req0_valid = 1'b1;
        req1_op = 3'd0; req1_a = 32'd2; req1_b = 32'd2; req1_valid = 1'b1;
        wait_accept(0, n);
        step();
        req0_valid = 1'b0;
        check("exec_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_data", resp_data, 32'd0);
        check("mid_rst_id", 32'(resp_id), 32'd0);
        check("mid_rst_zero", 32'(resp_zero), 32'd0);
        req1_valid = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_stale_resp", 32'(resp_valid), 32'd0);
        end
        step();
        req0_op = 3'd0; req0_a = 32'd1; req0_b = 32'd1; req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_any_grant(who);
        check("post_rst_grant", 32'(who), 32'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_valid(m);
        check("post_rst_data", resp_data, 32'd2);
        step();

        // Unused opcodes: result 0, zero from a-b, latency 1
        req0_op = 3'd7; req0_a = 32'd3; req0_b = 32'd3; req0_valid = 1'b1;
        wait_accept(0, n);
        step();
        req0_valid = 1'b0;
        wait_valid(m);
        check("ill7_latency", 32'(m - n), 32'd2);
        check("ill7_data", resp_data, 32'd0);
        check("ill7_zero", 32'(resp_zero), 32'd1);
        step();
        req0_op = 3'd5; req0_a = 32'd4; req0_b = 32'd3; req0_valid = 1'b1;
        wait_accept(0, n);
        step();
        req0_valid = 1'b0;
        wait_valid(m);
        check("ill5_data", resp_data, 32'd0);
        check("ill5_zero", 32'(resp_zero), 32'd0);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
